// File: rtl/conf_bus_arb.sv
// rtl/conf_bus_arb.sv - two-requester sequencer/arbiter for the 16-bit configuration bus
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   r0_* / r1_*                  requester 0 (register window) / requester 1 (init sequencer):
//                                req/write/addr/wdata in; ack/err/rdata out
//   conf_addr, conf_wdata        registered configuration bus address and write data
//   conf_write                   write strobe, high only in the ACCESS cycle of a matched write
//   conf_match, conf_rdata       OR of source match lines, muxed source read data
//   busy                         high whenever an access is in progress

module conf_bus_arb #(
    parameter int unsigned SETTLE     = 2,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [15:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [15:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [15:0] r1_rdata,

    output logic [15:0] conf_addr,
    output logic [15:0] conf_wdata,
    output logic        conf_write,
    input  logic        conf_match,
    input  logic [15:0] conf_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The counter runs SETTLE-1 down to 0, giving exactly SETTLE cycles in ST_SETTLE.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        cur_write_q, cur_write_d;
    logic        err_q, err_d;
    logic [15:0] conf_addr_q, conf_addr_d;
    logic [15:0] conf_wdata_q, conf_wdata_d;
    logic [15:0] r0_rdata_q, r0_rdata_d;
    logic [15:0] r1_rdata_q, r1_rdata_d;
    logic        pick;
    logic [15:0] access_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;  // requester 0 wins the first tie
            cur_write_q  <= 1'b0;
            err_q        <= 1'b0;
            conf_addr_q  <= 16'h0000;
            conf_wdata_q <= 16'h0000;
            r0_rdata_q   <= 16'h0000;
            r1_rdata_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cur_write_q  <= cur_write_d;
            err_q        <= err_d;
            conf_addr_q  <= conf_addr_d;
            conf_wdata_q <= conf_wdata_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cur_write_d  = cur_write_q;
        err_d        = err_q;
        conf_addr_d  = conf_addr_q;
        conf_wdata_d = conf_wdata_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        pick         = 1'b0;
        // An unmatched read returns zero rather than whatever the mux happens to drive.
        access_rdata = conf_match ? conf_rdata : 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    if (r0_req && r1_req) begin
                        pick = PRIO_FIXED ? 1'b0 : ~last_grant_q;
                    end else begin
                        pick = r1_req;
                    end
                    grant_d      = pick;
                    last_grant_d = pick;
                    conf_addr_d  = pick ? r1_addr  : r0_addr;
                    conf_wdata_d = pick ? r1_wdata : r0_wdata;
                    cur_write_d  = pick ? r1_write : r0_write;
                    cnt_d        = CNT_INIT;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                err_d = ~conf_match;
                if (!cur_write_q) begin
                    if (grant_q) begin
                        r1_rdata_d = access_rdata;
                    end else begin
                        r0_rdata_d = access_rdata;
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign conf_write = (state_q == ST_ACCESS) && cur_write_q && conf_match;
    assign r0_ack     = (state_q == ST_DONE) && !grant_q;
    assign r1_ack     = (state_q == ST_DONE) &&  grant_q;
    assign r0_err     = r0_ack && err_q;
    assign r1_err     = r1_ack && err_q;
    assign r0_rdata   = r0_rdata_q;
    assign r1_rdata   = r1_rdata_q;
    assign conf_addr  = conf_addr_q;
    assign conf_wdata = conf_wdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
